if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction fetch stage and IF/ID pipeline register.
//
// Keeps the PC and issues word-aligned fetches to the instruction memory. It
// loads the returned word into IF/ID, or parks it in a hold buffer while the
// hazard unit stalls decode. A small FSM handles redirects:
//   FETCH : a request is outstanding at pc.
//   HOLD  : a fetched word is parked and no request is issued.
//   KILL  : a redirect arrived while a request was still outstanding. The
//           word that returns is dropped and the latched target is taken.
//
// Optional build macro IF_STALL_CNT_EN adds the stall_cycles output. This
// counter counts cycles that wait on memory or sit in HOLD.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Wr_en,
  input  logic        IF_ID_Wr_en,
  input  logic        IF_ID_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        IF_ID_valid
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] target_q, target_d;
  logic        ifid_load;
  logic [31:0] ifid_instr_d;
  logic [31:0] pc_plus4;
  logic [31:0] redir_aligned;

  // The low two bits of the target are dropped, so pc stays word aligned.
  // The +4 wraps naturally modulo 2^32.
  assign redir_aligned = {redirect_pc[31:2], 2'b00};
  assign pc_plus4      = pc_q + 32'd4;

  assign imem_req  = (state_q != HOLD);
  assign imem_addr = pc_q;

  // Next-state, next-pc and IF/ID load decision; redirect outranks stalls.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    target_d     = target_q;
    ifid_load    = 1'b0;
    ifid_instr_d = hold_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_d = redir_aligned;
          end else begin
            target_d = redir_aligned;
            state_d  = KILL;
          end
        end else if (imem_ack) begin
          if (IF_ID_Wr_en) begin
            ifid_load    = 1'b1;
            ifid_instr_d = imem_rdata;
            if (PC_Wr_en) pc_d = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_aligned;
          state_d = FETCH;
        end else if (IF_ID_Wr_en) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          state_d   = FETCH;
        end
      end
      KILL: begin
        if (redirect_valid) target_d = redir_aligned;
        if (imem_ack) begin
          pc_d    = redirect_valid ? redir_aligned : target_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State, PC, hold buffer and latched redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the hold buffer is a plain register, not a memory, so it is reset along with everything else.
      state_q  <= FETCH;
      pc_q     <= RESET_PC_ALIGNED;
      hold_q   <= '0;
      target_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      target_q <= target_d;
    end
  end

  // IF/ID register. A flush beats any load and keeps PC+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_Instruction <= '0;
      IF_ID_PC_plus4    <= '0;
      IF_ID_valid       <= 1'b0;
    end else if (IF_ID_flush) begin
      IF_ID_Instruction <= '0;
      IF_ID_valid       <= 1'b0;
    end else if (ifid_load) begin
      IF_ID_Instruction <= ifid_instr_d;
      IF_ID_PC_plus4    <= pc_plus4;
      IF_ID_valid       <= 1'b1;
    end
  end

`ifdef IF_STALL_CNT_EN
  // Counts cycles that wait on memory or sit in HOLD. The counter wraps at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((imem_req && !imem_ack) || (state_q == HOLD)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
